// File: rtl/accum_initiator.sv
// accum_initiator
//
// Initiator side of the 4-lane accumulator en/done handshake. Vectors offered
// by a producer are buffered in a small FIFO. Each vector becomes one
// accumulate transaction: en is raised with the vector on add, the block
// waits for done, then drops en and waits for done to fall. A shadow copy of
// the expected accumulator contents is kept and compared against the
// responder's accum lanes when each transaction completes.
//
// Handshakes:
//   push side : a vector transfers on a rising edge where push_valid and
//               push_ready are both high; push_ready is simply !full.
//   en/done   : en rises with add stable; the responder raises done (with
//               accum updated on that same edge); en falls; the responder
//               drops done; only then may the next request start.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   push_valid/ready/data   producer interface, 4 lanes of ADD_WIDTH
//   en, add                 request and lane addends to the responder
//   accum, done             responder accumulator lanes and completion flag
//   result_valid            one-cycle pulse per completed transaction
//   mismatch                per-lane compare failure, held until next result
//   error_sticky            any mismatch or timeout since reset
//   txn_count               completed transactions (wraps at 2^16)
//   busy                    FSM active or FIFO holding data

module accum_initiator #(
    parameter int ACCUM_WIDTH = 32,
    parameter int ADD_WIDTH   = 16,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [ADD_WIDTH-1:0]   push_data [4],
    output logic                   en,
    output logic [ADD_WIDTH-1:0]   add [4],
    input  logic [ACCUM_WIDTH-1:0] accum [4],
    input  logic                   done,
    output logic                   result_valid,
    output logic [3:0]             mismatch,
    output logic                   error_sticky,
    output logic [15:0]            txn_count,
    output logic                   busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    // The timer starts at 0 on entry to a waiting state, so reaching
    // TIMEOUT-1 without the awaited done level means TIMEOUT cycles elapsed.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [ADD_WIDTH-1:0] mem_q [DEPTH][4];
    logic [ADD_WIDTH-1:0] mem_d [DEPTH][4];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    // No bypass: a full FIFO refuses a push even if it pops the same cycle.
    assign push_ready = (count_q != CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign push       = push_valid && push_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                mem_d[wr_ptr_q][i] = push_data[i];
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------
    // Transaction FSM and checking
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic                   en_q, en_d;
    logic [ADD_WIDTH-1:0]   add_q [4];
    logic [ADD_WIDTH-1:0]   add_d [4];
    logic [ACCUM_WIDTH-1:0] shadow_q [4];
    logic [ACCUM_WIDTH-1:0] shadow_d [4];
    logic                   result_valid_q, result_valid_d;
    logic [3:0]             mismatch_q, mismatch_d;
    logic                   error_sticky_q, error_sticky_d;
    logic [15:0]            txn_count_q, txn_count_d;
    logic [TMR_W-1:0]       timer_q, timer_d;

    always_comb begin
        state_d        = state_q;
        en_d           = en_q;
        add_d          = add_q;
        shadow_d       = shadow_q;
        result_valid_d = 1'b0;
        mismatch_d     = mismatch_q;
        error_sticky_d = error_sticky_q;
        txn_count_d    = txn_count_q;
        timer_d        = timer_q;
        pop            = 1'b0;

        case (state_q)
            S_IDLE: begin
                // done is deliberately not looked at here.
                en_d = 1'b0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    add_d   = mem_q[rd_ptr_q];
                    en_d    = 1'b1;
                    timer_d = '0;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (done) begin
                    // accum was updated on the same edge that raised done,
                    // so it is compared against the post-add shadow now.
                    for (int i = 0; i < 4; i++) begin
                        shadow_d[i]   = shadow_q[i] + ACCUM_WIDTH'(add_q[i]);
                        mismatch_d[i] = (accum[i] != shadow_d[i]);
                    end
                    if (mismatch_d != 4'b0000) begin
                        error_sticky_d = 1'b1;
                    end
                    result_valid_d = 1'b1;
                    txn_count_d    = txn_count_q + 16'd1;
                    en_d           = 1'b0;
                    timer_d        = '0;
                    state_d        = S_RELEASE;
                end else if (timer_q == TMR_LAST) begin
                    // Abandon the vector: no shadow update, no result.
                    error_sticky_d = 1'b1;
                    en_d           = 1'b0;
                    timer_d        = '0;
                    state_d        = S_RELEASE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            S_RELEASE: begin
                en_d = 1'b0;
                if (!done) begin
                    state_d = S_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    error_sticky_d = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            default: begin
                en_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            en_q           <= 1'b0;
            result_valid_q <= 1'b0;
            mismatch_q     <= 4'b0000;
            error_sticky_q <= 1'b0;
            txn_count_q    <= 16'd0;
            timer_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            for (int i = 0; i < 4; i++) begin
                add_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            en_q           <= en_d;
            result_valid_q <= result_valid_d;
            mismatch_q     <= mismatch_d;
            error_sticky_q <= error_sticky_d;
            txn_count_q    <= txn_count_d;
            timer_q        <= timer_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            add_q          <= add_d;
            shadow_q       <= shadow_d;
        end
    end

    assign en           = en_q;
    assign add          = add_q;
    assign result_valid = result_valid_q;
    assign mismatch     = mismatch_q;
    assign error_sticky = error_sticky_q;
    assign txn_count    = txn_count_q;
    assign busy         = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_accum_initiator.sv
`timescale 1ns/1ps

module tb_accum_initiator;

    localparam int AW = 32;
    localparam int DW = 16;
    localparam int W  = 4 * DW;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data [4];
    logic          en;
    logic [DW-1:0] add [4];
    logic [AW-1:0] resp_acc [4];
    logic          done;
    logic          result_valid;
    logic [3:0]    mismatch;
    logic          error_sticky;
    logic [15:0]   txn_count;
    logic          busy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    accum_initiator #(
        .ACCUM_WIDTH(AW),
        .ADD_WIDTH  (DW),
        .DEPTH      (4),
        .TIMEOUT    (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_data   (push_data),
        .en          (en),
        .add         (add),
        .accum       (resp_acc),
        .done        (done),
        .result_valid(result_valid),
        .mismatch    (mismatch),
        .error_sticky(error_sticky),
        .txn_count   (txn_count),
        .busy        (busy)
    );

    // ------------------------------------------------------------------
    // Responder model: adds on the edge it raises done, drops done once
    // en is gone. corrupt_mask adds 1 to the selected lanes.
    // ------------------------------------------------------------------
    bit       resp_on;
    bit       random_lat;
    bit [3:0] corrupt_mask;
    int       resp_lat;
    int       resp_wait;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            done      <= 1'b0;
            resp_wait <= 0;
            resp_lat  <= 0;
            for (int i = 0; i < 4; i++) resp_acc[i] <= '0;
        end else if (resp_on) begin
            if (en && !done) begin
                if (resp_wait >= resp_lat) begin
                    for (int i = 0; i < 4; i++)
                        resp_acc[i] <= resp_acc[i] + AW'(add[i]) + AW'(corrupt_mask[i]);
                    done      <= 1'b1;
                    resp_wait <= 0;
                    if (random_lat) resp_lat <= $urandom_range(0, 3);
                end else begin
                    resp_wait <= resp_wait + 1;
                end
            end else if (!en && done) begin
                done <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard / reference model
    // ------------------------------------------------------------------
    logic [W-1:0]  exp_q[$];
    logic [AW-1:0] m_shadow [4];
    logic [15:0]   m_txn;
    logic          m_err;
    int            rv_count = 0;
    int            last_rv_cyc = -1;
    bit            chk_gap = 0;
    logic          rv_prev = 1'b0;
    logic [W-1:0]  mv;
    logic [3:0]    exp_mm;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack4(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                                           input logic [DW-1:0] l2, input logic [DW-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Result monitor: on every completion, pop the oldest accepted vector,
    // advance the expected sums and derive every result-side output.
    always @(negedge clk) begin
        if (!reset) begin
            if (rv_prev === 1'b1) check_val("rv_one_cycle", result_valid, 0);
            if (result_valid === 1'b1) begin
                rv_count++;
                if (exp_q.size() == 0) begin
                    check_val("rv_unexpected", result_valid, 0);
                end else begin
                    mv = exp_q.pop_front();
                    check_val("add_lanes", {add[3], add[2], add[1], add[0]}, mv);
                    for (int i = 0; i < 4; i++) begin
                        m_shadow[i] = m_shadow[i] + AW'(mv[DW*i +: DW]);
                        exp_mm[i]   = (resp_acc[i] != m_shadow[i]);
                    end
                    m_txn = m_txn + 16'd1;
                    if (exp_mm != 4'b0000) m_err = 1'b1;
                    check_val("mismatch", mismatch, exp_mm);
                    check_val("txn_count", txn_count, m_txn);
                    check_val("error_sticky", error_sticky, m_err);
                    if (chk_gap && last_rv_cyc >= 0) check_val("txn_gap", cyc - last_rv_cyc, 5);
                end
                last_rv_cyc = cyc;
            end
            rv_prev = result_valid;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        push_valid   = 1'b0;
        resp_on      = 1'b0;
        random_lat   = 1'b0;
        corrupt_mask = 4'b0000;
        exp_q.delete();
        for (int i = 0; i < 4; i++) m_shadow[i] = '0;
        m_txn       = 16'd0;
        m_err       = 1'b0;
        rv_prev     = 1'b0;
        last_rv_cyc = -1;
        chk_gap     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_en", en, 0);
        check_val("rst_push_ready", push_ready, 1);
        check_val("rst_result_valid", result_valid, 0);
        check_val("rst_mismatch", mismatch, 0);
        check_val("rst_error_sticky", error_sticky, 0);
        check_val("rst_txn_count", txn_count, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_add", {add[3], add[2], add[1], add[0]}, 0);
    endtask

    task automatic push_vec(input logic [W-1:0] v, input int max_tries, output bit acc);
        acc = 1'b0;
        for (int t = 0; t < max_tries && !acc; t++) begin
            @(negedge clk);
            push_valid = 1'b1;
            for (int i = 0; i < 4; i++) push_data[i] = v[DW*i +: DW];
            acc = push_ready;
            @(posedge clk);
            if (acc) exp_q.push_back(v);
            #1 push_valid = 1'b0;
        end
    endtask

    task automatic wait_rv(input int target, input int budget);
        int n = 0;
        while (rv_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_result", rv_count >= target, 1);
    endtask

    task automatic wait_en(input logic val, input int budget);
        int n = 0;
        while (en !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_en", en, val);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    bit acc;
    int base;
    int n_acc;
    int cnt;

    initial begin
        reset = 1'b1;
        push_valid = 1'b0;
        for (int i = 0; i < 4; i++) push_data[i] = '0;
        resp_on = 1'b0;
        random_lat = 1'b0;
        corrupt_mask = 4'b0000;
        do_reset();

        // Single vector: en one cycle after the push, then a clean result.
        resp_on = 1'b1;
        push_vec(pack4(16'd1, 16'd2, 16'd3, 16'd4), 1, acc);
        check_val("t1_accept", acc, 1);
        check_val("t1_en_not_yet", en, 0);
        @(posedge clk); #1;
        check_val("t1_en_rise", en, 1);
        wait_rv(1, 20);
        check_val("t1_txn_count", txn_count, 1);
        check_val("t1_mismatch", mismatch, 0);

        // Carry out of the add width into the accumulator width.
        do_reset();
        resp_on = 1'b1;
        base = rv_count;
        push_vec(pack4(16'hFFFF, 16'd0, 16'd0, 16'd0), 4, acc);
        push_vec(pack4(16'hFFFF, 16'd0, 16'd0, 16'd0), 20, acc);
        wait_rv(base + 2, 40);
        check_val("t2_lane0", resp_acc[0], 32'h1FFFE);
        check_val("t2_mismatch", mismatch, 0);
        check_val("t2_txn_count", txn_count, 2);

        // Stall the responder, fill the FIFO behind the in-flight vector.
        do_reset();
        push_vec({$urandom, $urandom}, 1, acc);
        wait_en(1'b1, 10);
        for (int k = 0; k < 4; k++) begin
            push_vec({$urandom, $urandom}, 1, acc);
            check_val("t3_fill_accept", acc, 1);
        end
        check_val("t3_full_ready", push_ready, 0);
        push_vec({$urandom, $urandom}, 1, acc);
        check_val("t3_fifth_rejected", acc, 0);
        check_val("t3_busy", busy, 1);
        chk_gap = 1'b1;
        base = rv_count;
        resp_on = 1'b1;
        wait_rv(base + 1, 20);
        wait_en(1'b1, 20);
        check_val("t3_ready_after_pop", push_ready, 1);
        wait_rv(base + 5, 80);
        chk_gap = 1'b0;
        check_val("t3_txn_count", txn_count, 5);
        repeat (3) @(negedge clk);
        check_val("t3_idle_busy", busy, 0);

        // Random traffic with random responder latency.
        random_lat = 1'b1;
        base = rv_count;
        n_acc = 0;
        for (int k = 0; k < 40; k++) begin
            push_vec({$urandom, $urandom}, 50, acc);
            if (acc) n_acc++;
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_rv(base + n_acc, 2000);
        repeat (4) @(negedge clk);
        check_val("rand_idle_busy", busy, 0);
        check_val("rand_error_sticky", error_sticky, 0);

        // Reset while a request is outstanding and a vector is queued.
        resp_on = 1'b0;
        random_lat = 1'b0;
        push_vec({$urandom, $urandom}, 10, acc);
        wait_en(1'b1, 20);
        push_vec({$urandom, $urandom}, 10, acc);
        check_val("mid_busy_before", busy, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("mid_en_async", en, 0);
        check_val("mid_busy", busy, 0);
        check_val("mid_txn_count", txn_count, 0);
        do_reset();
        repeat (3) @(negedge clk);
        check_val("mid_flushed_en", en, 0);
        check_val("mid_flushed_busy", busy, 0);

        // Responder never answers: timeout after 64 cycles of en.
        base = rv_count;
        push_vec(pack4(16'd7, 16'd8, 16'd9, 16'd10), 1, acc);
        wait_en(1'b1, 10);
        cnt = 0;
        while (en === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check_val("to_en_cycles", cnt, 64);
        check_val("to_error_sticky", error_sticky, 1);
        check_val("to_no_result", rv_count, base);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        check_val("to_busy", busy, 0);
        check_val("to_en", en, 0);

        // Lane 2 corrupted by the responder.
        do_reset();
        resp_on = 1'b1;
        corrupt_mask = 4'b0100;
        base = rv_count;
        push_vec(pack4(16'd5, 16'd5, 16'd5, 16'd5), 1, acc);
        wait_rv(base + 1, 20);
        check_val("cor_mismatch", mismatch, 4'b0100);
        check_val("cor_error_sticky", error_sticky, 1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
